// File: rtl/rambus_arbiter.sv
// Round-robin N-master Wishbone arbiter in front of the rambus RAM slave,
// with cycle-long bus locking and a per-access stb timeout that returns err.
module rambus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 64,
    localparam int SEL_W    = DATA_W / 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N_MASTERS-1:0]        m_cyc_i,
    input  logic [N_MASTERS-1:0]        m_stb_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0] m_dat_i,
    input  logic [N_MASTERS*SEL_W-1:0]  m_sel_i,
    output logic [DATA_W-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]        m_ack_o,
    output logic [N_MASTERS-1:0]        m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [ADDR_W-1:0]           s_addr_o,
    output logic [DATA_W-1:0]           s_dat_o,
    output logic [SEL_W-1:0]            s_sel_o,
    input  logic [DATA_W-1:0]           s_dat_i,
    input  logic                        s_ack_i,
    output logic [N_MASTERS-1:0]        grant_o
);

    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_MASTERS - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             busy;
    logic             own_cyc;
    logic             own_stb;
    logic             timeout_hit;

    // Search starts just after the last owner, so nobody can win twice in a row
    // while another master is requesting.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pick_valid = 1'b0;
        pick_idx   = last_q;
        cand       = last_q;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_MASTERS);
            if (!pick_valid && m_cyc_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // While BUSY, last_q holds the index of the current owner.
    assign busy        = (state_q == BUSY);
    assign own_cyc     = busy & m_cyc_i[last_q];
    assign own_stb     = own_cyc & m_stb_i[last_q];
    assign timeout_hit = (TIMEOUT != 0) && own_stb && !s_ack_i && (tcnt_q == TCNT_MAX);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tcnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = N_MASTERS'(1) << pick_idx;
                    last_d  = pick_idx;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (own_stb && !s_ack_i && !timeout_hit) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous, sampled only at the clock edge; state uses <= so
        // every register updates from the same pre-edge values.
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign s_cyc_o  = own_cyc;
    assign s_stb_o  = own_stb & ~timeout_hit;
    assign s_we_o   = busy & m_we_i[last_q];
    assign s_addr_o = busy ? m_addr_i[int'(last_q)*ADDR_W +: ADDR_W] : '0;
    assign s_dat_o  = busy ? m_dat_i[int'(last_q)*DATA_W +: DATA_W] : '0;
    assign s_sel_o  = busy ? m_sel_i[int'(last_q)*SEL_W +: SEL_W] : '0;
    assign m_dat_o  = s_dat_i;
    assign grant_o  = grant_q;

    // A reset arriving mid-access must not let a late ack or err escape.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (reset_n) begin
            m_ack_o[last_q] = s_ack_i & s_stb_o;
            m_err_o[last_q] = timeout_hit;
        end
    end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed bench for rambus_arbiter (2 masters, TIMEOUT=4): stimulus pushes
// expected ack/err responses, a negedge monitor pops and compares them.
module tb_rambus_arbiter;

    localparam int NM = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    localparam logic [AW-1:0] ADDR_TAB [NM] = '{10'h005, 10'h3A0};
    localparam logic [DW-1:0] DAT_TAB  [NM] = '{32'hA0A0_0001, 32'hB1B1_0002};
    localparam logic [SW-1:0] SEL_TAB  [NM] = '{4'hF, 4'h3};

    typedef struct {
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [DW-1:0] rdata;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdat;
        logic [SW-1:0] sel;
        logic          stb;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*SW-1:0] m_sel;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack_i;
    logic [NM-1:0]    grant_o;

    assign m_addr = {ADDR_TAB[1], ADDR_TAB[0]};
    assign m_dat  = {DAT_TAB[1], DAT_TAB[0]};
    assign m_sel  = {SEL_TAB[1], SEL_TAB[0]};

    rambus_arbiter #(
        .N_MASTERS(NM),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT  (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_addr_i(m_addr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_addr_o(s_addr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .grant_o (grant_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic step(input logic [NM-1:0] cyc, input logic [NM-1:0] stb,
                        input logic [NM-1:0] we, input logic ack, input logic [DW-1:0] sdat,
                        input logic rst, input logic [NM-1:0] e_grant, input logic e_scyc,
                        input logic e_sstb, input logic [NM-1:0] e_ack,
                        input logic [NM-1:0] e_err, input string tag);
        int gi;
        gi      = e_grant[1] ? 1 : 0;
        reset_n = rst;
        m_cyc   = cyc;
        m_stb   = stb;
        m_we    = we;
        s_ack_i = ack;
        s_dat_i = sdat;
        if (e_ack != '0 || e_err != '0)
            sb_q.push_back('{ack: e_ack, err: e_err, rdata: sdat, addr: ADDR_TAB[gi],
                             we: we[gi], wdat: DAT_TAB[gi], sel: SEL_TAB[gi], stb: e_sstb});
        @(negedge clock);
        check({tag, "/grant"}, 32'(grant_o), 32'(e_grant));
        check({tag, "/s_cyc"}, 32'(s_cyc_o), 32'(e_scyc));
        check({tag, "/s_stb"}, 32'(s_stb_o), 32'(e_sstb));
        @(posedge clock);
        #1;
    endtask

    // Monitor: any ack or err presented by the DUT must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (m_ack_o !== '0 || m_err_o !== '0) begin
                check("mon/ack_err_overlap", 32'(m_ack_o & m_err_o), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon/unexpected: got ack=%0h err=%0h expected none",
                             m_ack_o, m_err_o);
                end else begin
                    e = sb_q.pop_front();
                    check("mon/ack",   32'(m_ack_o),  32'(e.ack));
                    check("mon/err",   32'(m_err_o),  32'(e.err));
                    check("mon/s_stb", 32'(s_stb_o),  32'(e.stb));
                    check("mon/addr",  32'(s_addr_o), 32'(e.addr));
                    check("mon/we",    32'(s_we_o),   32'(e.we));
                    check("mon/wdat",  s_dat_o,       e.wdat);
                    check("mon/sel",   32'(s_sel_o),  32'(e.sel));
                    if (e.ack != '0)
                        check("mon/rdata", m_dat_o, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        @(posedge clock);
        #1;

        // Reset holds everything idle even with requests and a stray slave ack.
        step(2'b11, 2'b11, 2'b00, 1'b1, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "rst_a");
        step(2'b11, 2'b11, 2'b00, 1'b1, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "rst_b");

        // Single read by master 0 at 0x005.
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t1_req");
        step(2'b01, 2'b01, 2'b00, 1'b1, 32'hCAFE_0001, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, "t1_ack");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "t1_drop");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t1_rst");

        // Both masters request continuously; single-beat cycles alternate owners.
        step(2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t2_c0");
        step(2'b11, 2'b11, 2'b00, 1'b1, 32'h1111_0000, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, "t2_c1");
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "t2_c2");
        step(2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t2_c3");
        step(2'b11, 2'b11, 2'b00, 1'b1, 32'h2222_0001, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, "t2_c4");
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, "t2_c5");
        step(2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t2_c6");
        step(2'b11, 2'b11, 2'b00, 1'b1, 32'h3333_0002, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, "t2_c7");
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "t2_c8");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t2_c9");

        // Master 0 locks the bus across three beats while master 1 waits.
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t3_d0");
        step(2'b11, 2'b01, 2'b00, 1'b1, 32'h4444_0000, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, "t3_d1");
        step(2'b11, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, "t3_d2");
        step(2'b11, 2'b01, 2'b01, 1'b1, 32'h4444_0001, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, "t3_d3");
        step(2'b11, 2'b01, 2'b00, 1'b1, 32'h4444_0002, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, "t3_d4");
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "t3_d5");
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t3_d6");
        step(2'b10, 2'b10, 2'b00, 1'b1, 32'h5555_0000, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, "t3_d7");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, "t3_d8");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t3_d9");

        // Slave never acks: err on the 4th stb cycle with s_stb forced low, then a retry.
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t4_e0");
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, "t4_e1");
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, "t4_e2");
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, "t4_e3");
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 2'b01, "t4_e4");
        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, "t4_e5");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "t4_e6");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t4_e7");

        // Ack arrives in the exact timeout cycle: ack wins, no err.
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t5_f0");
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, "t5_f1");
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, "t5_f2");
        step(2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, "t5_f3");
        step(2'b10, 2'b10, 2'b00, 1'b1, 32'h6666_0004, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, "t5_f4");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, "t5_f5");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t5_f6");

        // Reset during a BUSY write releases the bus, suppresses the ack, restarts at master 0.
        step(2'b01, 2'b01, 2'b01, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t6_g0");
        step(2'b01, 2'b01, 2'b01, 1'b1, 32'h7777_0000, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, "t6_g1");
        step(2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t6_g2");
        step(2'b11, 2'b11, 2'b00, 1'b1, 32'h8888_0001, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, "t6_g3");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "t6_g4");
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "t6_g5");

        @(negedge clock);
        check("sb/drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
